dir_cmd_queue: RTL and testbench

// - Consumes the one-cycle press pulses of the four direction-button debouncing_circuit instances.
// - Encodes the pulses into 2-bit direction commands and buffers them in a small FIFO.
// - Presents the commands to the Pac-Man movement logic over a valid/ready handshake.
// - Turns are requested ahead of the tile where they can be taken, so quick taps are not lost.

---
 rtl/pacman_pkg.sv | 15 +
 rtl/dir_priority_enc.sv | 34 +++
 rtl/dir_cmd_queue.sv | 117 +++++++++++
 tb/tb_dir_cmd_queue.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared Pac-Man definitions.
// Holds the 2-bit direction encoding. The command queue, the movement logic
// and the sprite renderer all use it.
package pacman_pkg;

    localparam int DIR_W = 2;

    typedef enum logic [DIR_W-1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

endpackage

// File: rtl/dir_priority_enc.sv
// Combinational encoder for the four direction press pulses.
// Ports:
//   up_p, down_p, left_p, right_p : one-cycle press pulses
//   push   : at least one pulse is present
//   dir    : the winning direction (up > down > left > right)
//   n_lost : number of pulses that lost arbitration this cycle (0..3)
module dir_priority_enc
    import pacman_pkg::*;
(
    input  logic       up_p,
    input  logic       down_p,
    input  logic       left_p,
    input  logic       right_p,
    output logic       push,
    output dir_e       dir,
    output logic [1:0] n_lost
);

    logic [2:0] cnt;

    always_comb begin
        cnt    = 3'(up_p) + 3'(down_p) + 3'(left_p) + 3'(right_p);
        push   = up_p | down_p | left_p | right_p;
        dir    = DIR_UP;
        if (up_p)         dir = DIR_UP;
        else if (down_p)  dir = DIR_DOWN;
        else if (left_p)  dir = DIR_LEFT;
        else if (right_p) dir = DIR_RIGHT;
        // Every pulse except the winner is lost; the count is at most 4, so
        // the count minus one fits in two bits.
        n_lost = push ? 2'(cnt - 3'd1) : 2'd0;
    end

endmodule

// File: rtl/dir_cmd_queue.sv
// Direction command queue.
// Buffers encoded button presses in a small show-ahead FIFO. The FIFO feeds
// the movement logic through a valid/ready handshake, so that a turn can be
// requested before the tile where it can be taken.
// Ports:
//   d_clk, rst         : clock; synchronous active-high reset
//   up_p .. right_p    : press pulses from the debouncers
//   cmd_ready          : consumer takes the head entry this cycle
//   cmd_valid, cmd_dir : head entry (registered)
//   level              : occupancy, 0..DEPTH
//   overflow           : sticky; set whenever a full queue replaced its newest entry
//   drop_cnt           : saturating count of discarded presses
module dir_cmd_queue
    import pacman_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     d_clk,
    input  logic                     rst,
    input  logic                     up_p,
    input  logic                     down_p,
    input  logic                     left_p,
    input  logic                     right_p,
    input  logic                     cmd_ready,
    output logic                     cmd_valid,
    output logic [DIR_W-1:0]         cmd_dir,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W+1)'(b);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    logic       enc_push;
    dir_e       enc_dir;
    logic [1:0] enc_lost;

    dir_priority_enc u_enc (
        .up_p    (up_p),
        .down_p  (down_p),
        .left_p  (left_p),
        .right_p (right_p),
        .push    (enc_push),
        .dir     (enc_dir),
        .n_lost  (enc_lost)
    );

    dir_e             mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic             pop, coalesce, do_push, replace, append;
    logic [PTR_W-1:0] newest_ptr, wr_idx;

    always_comb begin
        pop        = (level_q != '0) & cmd_ready;
        newest_ptr = wr_ptr_q - PTR_W'(1);
        // The newest entry only absorbs an equal push if it is still queued
        // after this cycle's pop; otherwise the push must be stored.
        coalesce   = enc_push && ((level_q - LVL_W'(pop)) != '0)
                     && (mem_q[newest_ptr] == enc_dir);
        do_push    = enc_push & ~coalesce;
        // A full queue with no pop overwrites the newest entry (latest intent wins).
        replace    = do_push & (level_q == FULL_LVL) & ~pop;
        append     = do_push & ~replace;
        wr_idx     = replace ? newest_ptr : wr_ptr_q;

        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(append);
        level_d    = level_q + LVL_W'(append) - LVL_W'(pop);
        overflow_d = overflow_q | replace;
        drop_d     = sat_add(drop_q, enc_lost);
    end

    always_ff @(posedge d_clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Storage carries no reset; its contents are only visible when level is non-zero.
    always_ff @(posedge d_clk) begin
        if (!rst && do_push) begin
            mem_q[wr_idx] <= enc_dir;
        end
    end

    assign cmd_valid = (level_q != '0);
    assign cmd_dir   = cmd_valid ? mem_q[rd_ptr_q] : DIR_UP;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_dir_cmd_queue.sv
module tb_dir_cmd_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic       d_clk = 1'b0;
    logic       rst = 1'b1;
    logic       up_p = 1'b0, down_p = 1'b0, left_p = 1'b0, right_p = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [1:0] cmd_dir;
    logic [2:0] level;
    logic       overflow;
    logic [7:0] drop_cnt;

    dir_cmd_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .d_clk     (d_clk),
        .rst       (rst),
        .up_p      (up_p),
        .down_p    (down_p),
        .left_p    (left_p),
        .right_p   (right_p),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd_dir   (cmd_dir),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 d_clk = ~d_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: an ordered list of queued directions plus counters.
    int m_q[$];
    int m_ovf  = 0;
    int m_drop = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit u, input bit d, input bit l,
                              input bit rt, input bit rdy);
        int  npress, win, size_after_pop;
        bit  pop;
        if (r) begin
            m_q.delete();
            m_ovf  = 0;
            m_drop = 0;
            return;
        end
        npress = int'(u) + int'(d) + int'(l) + int'(rt);
        win = u ? 0 : d ? 1 : l ? 2 : 3;
        pop = (m_q.size() > 0) && rdy;
        if (npress > 1) m_drop = (m_drop + npress - 1 > 255) ? 255 : m_drop + npress - 1;
        size_after_pop = m_q.size() - int'(pop);
        if (npress > 0 && size_after_pop >= 1 && m_q[m_q.size()-1] == win) begin
            if (pop) void'(m_q.pop_front());
        end else if (npress > 0) begin
            if (m_q.size() == DEPTH && !pop) begin
                m_q[m_q.size()-1] = win;
                m_ovf = 1;
            end else begin
                if (pop) void'(m_q.pop_front());
                m_q.push_back(win);
            end
        end else if (pop) begin
            void'(m_q.pop_front());
        end
    endtask

    task automatic step(input bit r, input bit u, input bit d, input bit l,
                        input bit rt, input bit rdy);
        rst = r; up_p = u; down_p = d; left_p = l; right_p = rt; cmd_ready = rdy;
        @(posedge d_clk);
        model_step(r, u, d, l, rt, rdy);
        #1;
        chk("level", int'(level), m_q.size());
        chk("valid", int'(cmd_valid), int'(m_q.size() != 0));
        chk("overflow", int'(overflow), m_ovf);
        chk("drop_cnt", int'(drop_cnt), m_drop);
        if (m_q.size() != 0) chk("head", int'(cmd_dir), m_q[0]);
    endtask

    task automatic press(input int dir, input bit rdy);
        step(0, dir == 0, dir == 1, dir == 2, dir == 3, rdy);
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 0, 0, 0, rdy);
    endtask

    initial begin
        // Reset held while right_p pulses
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 1);
        chk("rst_level", int'(level), 0);
        chk("rst_valid", int'(cmd_valid), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        chk("rst_dir", int'(cmd_dir), 0);

        // Single press, one-cycle latency, then pop
        idle(0);
        press(2, 0);
        chk("single_valid", int'(cmd_valid), 1);
        chk("single_dir", int'(cmd_dir), 2);
        idle(1);
        chk("single_pop", int'(cmd_valid), 0);
        idle(1);
        chk("ready_empty", int'(level), 0);

        // Priority: up + left + right
        step(0, 1, 0, 1, 1, 0);
        chk("prio_level", int'(level), 1);
        chk("prio_dir", int'(cmd_dir), 0);
        chk("prio_drop", int'(drop_cnt), 2);

        // Coalesce
        step(1, 0, 0, 0, 0, 0);
        press(1, 0); press(1, 0); press(2, 0);
        chk("coal_level", int'(level), 2);
        chk("coal_head", int'(cmd_dir), 1);
        idle(1);
        chk("coal_second", int'(cmd_dir), 2);
        step(1, 0, 0, 0, 0, 0);
        press(3, 0);
        press(3, 1);
        chk("coal_kept_level", int'(level), 1);
        chk("coal_kept_head", int'(cmd_dir), 3);
        chk("coal_kept_drop", int'(drop_cnt), 0);

        // Full: replace newest, then push with pop
        step(1, 0, 0, 0, 0, 0);
        press(0, 0); press(1, 0); press(2, 0); press(3, 0); press(0, 0);
        chk("full_level", int'(level), 4);
        chk("full_ovf", int'(overflow), 1);
        chk("full_head", int'(cmd_dir), 0);
        press(1, 1);
        chk("fullpp_level", int'(level), 4);
        idle(1); chk("drain0", int'(cmd_dir), 2);
        idle(1); chk("drain1", int'(cmd_dir), 0);
        idle(1); chk("drain2", int'(cmd_dir), 1);
        idle(1); chk("drain_empty", int'(cmd_valid), 0);

        // Mid-operation reset discards entries and the same-cycle pulse
        press(2, 0); press(3, 0);
        step(1, 1, 0, 0, 0, 0);
        chk("midrst_level", int'(level), 0);

        // Wrap: alternating push / pop
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) press(int'($urandom_range(0, 3)), 0);
            else            idle(1);
        end

        // Mixed random traffic
        for (int i = 0; i < 600; i++) begin
            step(0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 1) == 1);
        end

        // Saturation of the drop counter
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 260; i++) step(0, 1, 1, 1, 1, $urandom_range(0, 1) == 1);
        chk("sat_drop", int'(drop_cnt), 255);
        step(0, 1, 1, 1, 1, 0);
        chk("sat_hold", int'(drop_cnt), 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
